regfile_2r1w: RTL

//   Parametrised register file: NREGS words of WIDTH bits, NRD combinational read ports, one write port.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_row.sv | 37 +++
 rtl/regfile_2r1w.sv | 101 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the byte-merge helper used by both the row write path
// and the read bypass path, so the stored and forwarded values cannot diverge.
package regfile_pkg;

    localparam int BYTE_W = 8;

    function automatic logic [BYTE_W-1:0] be_merge(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/regfile_row.sv
// One register-file entry: WIDTH bits with per-byte write enables and a
// synchronous reset to a configurable value.
module regfile_row
    import regfile_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [WIDTH/BYTE_W-1:0] be,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        q
);

    localparam int NBE = WIDTH / BYTE_W;

    logic [WIDTH-1:0] merged;

    for (genvar k = 0; k < NBE; k++) begin : g_byte
        assign merged[k*BYTE_W +: BYTE_W] =
            be_merge(q[k*BYTE_W +: BYTE_W], wdata[k*BYTE_W +: BYTE_W], be[k]);
    end

    // Entry storage; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (we) begin
            q <= merged;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file: NREGS x WIDTH, NRD combinational read ports,
// one byte-enabled write port, optional hardwired-zero entry 0 and write bypass.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               NREGS     = 32,
    parameter int               NRD       = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               ZERO_REG  = 1,
    parameter int               BYPASS    = 1,
    parameter int               AW        = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH/BYTE_W-1:0] wr_be,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NRD*AW-1:0]       rd_addr,
    output logic [NRD*WIDTH-1:0]    rd_data,
    output logic                    wr_err
);

    localparam int NBE = WIDTH / BYTE_W;

    logic [WIDTH-1:0] mem [NREGS];
    logic             wr_in_range;
    logic             wr_open;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;

    assign wr_in_range = 32'(wr_addr) < NREGS;
    assign wr_open     = wr_en && wr_in_range && !((ZERO_REG != 0) && (wr_addr == '0));

    for (genvar i = 0; i < NREGS; i++) begin : g_row
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign mem[i] = '0;
        end else begin : g_store
            regfile_row #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_row (
                .clk   (clk),
                .reset (reset),
                .we    (wr_open && (wr_addr == AW'(i))),
                .be    (wr_be),
                .wdata (wr_data),
                .q     (mem[i])
            );
        end
    end

    // Current contents of the write target, feeding the bypass merge.
    always_comb begin
        wr_old = '0;
        if (wr_in_range) begin
            wr_old = mem[wr_addr];
        end else begin
            wr_old = '0;
        end
    end

    for (genvar k = 0; k < NBE; k++) begin : g_merge
        assign wr_merged[k*BYTE_W +: BYTE_W] =
            be_merge(wr_old[k*BYTE_W +: BYTE_W], wr_data[k*BYTE_W +: BYTE_W], wr_be[k]);
    end

    // Out-of-range write flag, valid for exactly the cycle after the attempt.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_in_range;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;

        assign ra = rd_addr[p*AW +: AW];

        // Read mux; bypass is suppressed during reset so reads show stored data.
        always_comb begin
            rd = '0;
            if (32'(ra) >= NREGS) begin
                rd = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end else if ((BYPASS != 0) && wr_open && !reset && (ra == wr_addr)) begin
                rd = wr_merged;
            end else begin
                rd = mem[ra];
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = rd;
    end

endmodule
